dist_ascii_tx: RTL and testbench
================================

Name: dist_ascii_tx

Overview:
Downstream of the ultrasonic ranging stage and upstream of the UART transmitter. Accepts one binary distance sample in cm and converts it to 3 BCD digits with a sequential double-dabble. Emits a fixed 8-byte ASCII record ("DDD cm\r\n") over a valid/ready byte interface that feeds the UART tx. Runs on the 12 MHz board clock.

Parameters:
DIST_W, 10, width of the dist_cm input.
MAX_CM, 400, sensor range limit in cm; used only when DIST_TX_OOR_EN is defined.

Ports:
hw_clk  input  1  system clock, 12 MHz.
rst  input  1  asynchronous, active-high reset.
dist_valid  input  1  one-cycle strobe; dist_cm is valid in this cycle.
dist_cm  input  DIST_W  measured distance, unsigned cm.
tx_data  output  8  ASCII byte to the UART.
tx_valid  output  1  tx_data is valid.
tx_ready  input  1  UART accepts the byte; transfer occurs when tx_valid && tx_ready at a hw_clk edge.
busy  output  1  high in any state other than IDLE.
sat  output  1  sticky flag: the last accepted sample was greater than 999. Updated on each accept.
dropped  output  1  one-cycle pulse when dist_valid arrives while busy=1.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-conversion or mid-send):
  - tx_valid=0, tx_data=8'h00, busy=0, sat=0, dropped=0.
  - FSM returns to IDLE; the BCD register and byte index are cleared.
  - A partially sent record is abandoned and is not resumed.
- States: IDLE -> CONV -> SEND -> IDLE.
- IDLE:
  - On dist_valid=1, latch dist_cm. If the value is greater than 999, substitute 999 and set sat=1; otherwise clear sat.
  - Go to CONV. busy goes high in the next cycle.
- CONV:
  - Double-dabble: exactly DIST_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left by 1.
  - After DIST_W cycles, go to SEND with byte index 0.
  - Latency from the dist_valid cycle to the first tx_valid=1 is DIST_W+1 cycles (11 at default).
- SEND, byte order:
  - idx0: hundreds digit.
  - idx1: tens digit.
  - idx2: units digit.
  - idx3: 8'h20 (space).
  - idx4: 8'h63 ('c').
  - idx5: 8'h6D ('m').
  - idx6: 8'h0D (CR).
  - idx7: 8'h0A (LF).
- Leading-zero suppression:
  - Hundreds digit is 8'h20 if zero.
  - Tens digit is 8'h20 if both hundreds and tens are zero.
  - The units digit is always a digit (8'h30 + n).
- Handshake:
  - tx_valid is asserted in SEND and held until accepted.
  - tx_data must not change while tx_valid=1 and tx_ready=0.
  - On acceptance, the next byte is presented in the following cycle. tx_valid may stay high back-to-back when tx_ready stays high.
  - The record is 8 accepted bytes; the minimum SEND time is 8 cycles.
- Return to IDLE:
  - On acceptance of idx7, tx_valid=0 and busy=0 in the next cycle.
  - dist_valid in that final-accept cycle is still counted as busy: it is dropped and dropped pulses.
- No queueing: any dist_valid while busy=1 is ignored, and dropped=1 for exactly one cycle.
- tx_ready is ignored when tx_valid=0.

Optional Feature:
Macro: DIST_TX_OOR_EN.
- Defined: a sample with dist_cm > MAX_CM bypasses CONV and emits the 5-byte record "OOR\r\n" (8'h4F 8'h4F 8'h52 8'h0D 8'h0A). First tx_valid comes 1 cycle after accept. sat is unaffected.
- Undefined: MAX_CM is unused; every sample is converted, with saturation at 999.

Decomposition:
- Package dist_tx_pkg holds:
  - the state enum;
  - ASCII constants (SPACE, C, M, CR, LF, ZERO, O, R);
  - REC_LEN=8 and OOR_LEN=5.
- Sub-module bin2bcd_seq: a sequential double-dabble with start/done handshake, a DIST_W-bit input and a 12-bit BCD output. The FSM and byte mux stay in dist_ascii_tx.

Test Plan:
- dist_cm=234, tx_ready=1 -> bytes 32 33 34 20 63 6D 0D 0A on consecutive cycles; first tx_valid 11 cycles after the strobe; sat=0.
- dist_cm=7 then dist_cm=0 -> "  7 cm\r\n" (20 20 37 ...) then "  0 cm\r\n" (20 20 30 ...).
- dist_cm=1023 -> "999 cm\r\n" and sat=1; the next sample of 50 -> " 50 cm\r\n" and sat=0.
- dist_cm=400 with tx_ready low for 5 cycles on idx2 -> tx_data stays 8'h30 with tx_valid=1 throughout; the record completes intact.
- Second strobe during SEND, and a strobe in the idx7-accept cycle -> each gives one dropped pulse and no extra bytes; rst at idx4 -> tx_valid=0 and busy=0 immediately; the next strobe of 123 gives a clean "123 cm\r\n".
- DIST_TX_OOR_EN defined, dist_cm=450 -> 4F 4F 52 0D 0A; dist_cm=400 -> normal "400 cm\r\n".

Source files
------------

// File: rtl/dist_ascii_tx_pkg.sv
// Shared types, ASCII constants and byte/BCD helpers for the distance-to-ASCII
// transmitter.
package dist_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_C     = 8'h63;
    localparam logic [7:0] ASCII_M     = 8'h6D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_O     = 8'h4F;
    localparam logic [7:0] ASCII_R     = 8'h52;

    localparam int REC_LEN = 8;
    localparam int OOR_LEN = 5;
    localparam int SAT_CM  = 999;

    // One double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [11:0] dabble_step(input logic [11:0] bcd);
        logic [11:0] r;
        r = bcd;
        for (int n = 0; n < 3; n++) begin
            if (r[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [7:0] rec_byte(input logic [2:0] idx, input logic [11:0] bcd);
        logic [7:0] b;
        // NOTE: default first so every path assigns b; the same habit in always_comb avoids latches.
        b = 8'h00;
        case (idx)
            3'd0: b = (bcd[11:8] == 4'd0) ? ASCII_SPACE : ASCII_ZERO + {4'd0, bcd[11:8]};
            3'd1: b = (bcd[11:4] == 8'd0) ? ASCII_SPACE : ASCII_ZERO + {4'd0, bcd[7:4]};
            3'd2: b = ASCII_ZERO + {4'd0, bcd[3:0]};
            3'd3: b = ASCII_SPACE;
            3'd4: b = ASCII_C;
            3'd5: b = ASCII_M;
            3'd6: b = ASCII_CR;
            3'd7: b = ASCII_LF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] oor_byte(input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0, 3'd1: b = ASCII_O;
            3'd2:       b = ASCII_R;
            3'd3:       b = ASCII_CR;
            3'd4:       b = ASCII_LF;
            default:    b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dist_ascii_tx_bin2bcd_seq.sv
// Sequential double-dabble: start loads the binary value, DIST_W shift cycles
// later bcd_o holds three BCD digits; done_o marks the cycle of the final shift.
module bin2bcd_seq
    import dist_tx_pkg::*;
#(
    parameter int DIST_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DIST_W-1:0] bin_i,
    output logic [11:0]       bcd_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(DIST_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIST_W);

    logic [DIST_W-1:0] bin_q;
    logic [11:0]       bcd_q;
    logic [CNT_W-1:0]  cnt_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (start_i) begin
            bin_q <= bin_i;
            bcd_q <= '0;
            cnt_q <= CNT_LOAD;
        end else if (cnt_q != '0) begin
            {bcd_q, bin_q} <= {dabble_step(bcd_q), bin_q} << 1;
            cnt_q          <= cnt_q - CNT_ONE;
        end
    end

    assign bcd_o  = bcd_q;
    assign done_o = (cnt_q == CNT_ONE);

endmodule

// File: rtl/dist_ascii_tx.sv
// Converts one distance sample to the ASCII record "DDD cm\r\n" on a valid/ready
// byte stream. Define DIST_TX_OOR_EN to emit "OOR\r\n" for samples above MAX_CM.
module dist_ascii_tx
    import dist_tx_pkg::*;
#(
    parameter int DIST_W = 10,
    parameter int MAX_CM = 400
) (
    input  logic              hw_clk,
    input  logic              rst,
    input  logic              dist_valid,
    input  logic [DIST_W-1:0] dist_cm,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              sat,
    output logic              dropped
);

`ifdef DIST_TX_OOR_EN
    localparam bit OOR_EN = 1'b1;
`else
    localparam bit OOR_EN = 1'b0;
`endif

    localparam logic [2:0] LAST_REC = 3'(REC_LEN - 1);
    localparam logic [2:0] LAST_OOR = 3'(OOR_LEN - 1);

    state_e            state_q;
    logic [2:0]        idx_q;
    logic              tx_valid_q;
    logic              sat_q;
    logic              dropped_q;
    logic              oor_q;

    logic              over_sat;
    logic              is_oor;
    logic              bcd_start;
    logic              bcd_done;
    logic [11:0]       bcd;
    logic [DIST_W-1:0] sample_d;
    logic [2:0]        last_idx;

    assign over_sat  = 32'(dist_cm) > SAT_CM;
    assign is_oor    = OOR_EN && (32'(dist_cm) > MAX_CM);
    assign sample_d  = over_sat ? DIST_W'(SAT_CM) : dist_cm;
    assign bcd_start = (state_q == ST_IDLE) && dist_valid && !is_oor;
    assign last_idx  = oor_q ? LAST_OOR : LAST_REC;

    bin2bcd_seq #(
        .DIST_W (DIST_W)
    ) u_bcd (
        .clk_i   (hw_clk),
        .rst_i   (rst),
        .start_i (bcd_start),
        .bin_i   (sample_d),
        .bcd_o   (bcd),
        .done_o  (bcd_done)
    );

    always_ff @(posedge hw_clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tx_valid_q <= 1'b0;
            sat_q      <= 1'b0;
            dropped_q  <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            // The final-accept cycle still counts as busy, so a strobe there is dropped.
            dropped_q <= dist_valid && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (dist_valid) begin
                        idx_q <= '0;
                        oor_q <= is_oor;
                        if (is_oor) begin
                            state_q    <= ST_SEND;
                            tx_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_CONV;
                            sat_q   <= over_sat;
                        end
                    end
                end
                ST_CONV: begin
                    if (bcd_done) begin
                        state_q    <= ST_SEND;
                        tx_valid_q <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        if (idx_q == last_idx) begin
                            state_q    <= ST_IDLE;
                            tx_valid_q <= 1'b0;
                            idx_q      <= '0;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Byte is decoded from registered index and digits only, so it holds during a stall.
    assign tx_data  = !tx_valid_q ? 8'h00 : (oor_q ? oor_byte(idx_q) : rec_byte(idx_q, bcd));
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != ST_IDLE);
    assign sat      = sat_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_dist_ascii_tx.sv
// Self-checking bench for dist_ascii_tx: directed and random samples checked
// against a decimal-arithmetic model of the ASCII record.
`timescale 1ns/1ps
module tb_dist_ascii_tx;

    localparam int DIST_W = 10;
    localparam int MAX_CM = 400;

    logic              hw_clk = 1'b0;
    logic              rst;
    logic              dist_valid;
    logic [DIST_W-1:0] dist_cm;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              sat;
    logic              dropped;

    int checks = 0;
    int errors = 0;

    byte unsigned exp_q[$];
    int           exp_lat;
    logic         exp_sat = 1'b0;

    always #42 hw_clk = ~hw_clk;

    dist_ascii_tx #(
        .DIST_W (DIST_W),
        .MAX_CM (MAX_CM)
    ) dut (
        .hw_clk     (hw_clk),
        .rst        (rst),
        .dist_valid (dist_valid),
        .dist_cm    (dist_cm),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .sat        (sat),
        .dropped    (dropped)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected record built from the decimal value, not from BCD nibbles.
    task automatic model(input int d);
        int v;
        exp_q.delete();
`ifdef DIST_TX_OOR_EN
        if (d > MAX_CM) begin
            exp_q   = '{8'h4F, 8'h4F, 8'h52, 8'h0D, 8'h0A};
            exp_lat = 1;
            return;
        end
`endif
        v       = (d > 999) ? 999 : d;
        exp_sat = (d > 999);
        exp_lat = DIST_W + 1;
        exp_q.push_back((v >= 100) ? 8'(8'h30 + v / 100) : 8'h20);
        exp_q.push_back((v >= 10) ? 8'(8'h30 + (v / 10) % 10) : 8'h20);
        exp_q.push_back(8'(8'h30 + v % 10));
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h63);
        exp_q.push_back(8'h6D);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low 5 cycles at stall_idx.
    // inj_idx >= 0 strobes dist_valid in the cycle that accepts that byte.
    task automatic run_record(input int d, input int mode, input int stall_idx, input int inj_idx);
        int           lat;
        int           ncyc;
        int           acc;
        int           stall_left;
        logic         r;
        logic         prev_stall;
        logic [7:0]   prev_data;
        logic         drop_pending;
        byte unsigned got[$];

        model(d);
        @(negedge hw_clk);
        dist_valid = 1'b1;
        dist_cm    = DIST_W'(d);
        tx_ready   = 1'b0;
        lat = 0;
        do begin
            @(negedge hw_clk);
            dist_valid = 1'b0;
            lat++;
            if (lat == 1) begin
                check("busy_rise", busy, 1);
                check("dropped_idle", dropped, 0);
            end
        end while (!tx_valid && lat < 50);
        check($sformatf("latency_%0d", d), lat, exp_lat);

        acc = 0; ncyc = 0; stall_left = 5; prev_stall = 1'b0; prev_data = 8'h00; drop_pending = 1'b0;
        while (acc < exp_q.size() && ncyc < 200) begin
            if (prev_stall) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, prev_data);
            end
            case (mode)
                1:       r = 1'($urandom_range(0, 1));
                2:       r = !(acc == stall_idx && stall_left > 0);
                default: r = 1'b1;
            endcase
            if (mode == 2 && !r) stall_left--;
            tx_ready = r;
            if (inj_idx >= 0 && acc == inj_idx && r && tx_valid) begin
                dist_valid   = 1'b1;
                dist_cm      = '1;
                drop_pending = 1'b1;
            end
            if (tx_valid && r) begin
                got.push_back(tx_data);
                acc++;
            end
            prev_stall = tx_valid && !r;
            prev_data  = tx_data;
            ncyc++;
            @(negedge hw_clk);
            dist_valid = 1'b0;
            if (drop_pending) begin
                check("dropped_pulse", dropped, 1);
                drop_pending = 1'b0;
            end
        end

        check($sformatf("rec_len_%0d", d), acc, exp_q.size());
        for (int i = 0; i < acc && i < exp_q.size(); i++)
            check($sformatf("byte%0d_of_%0d", i, d), got[i], exp_q[i]);
        check("tx_valid_end", tx_valid, 0);
        check("busy_end", busy, 0);
        if (mode == 0) check("send_cycles", ncyc, exp_q.size());
        tx_ready = 1'b1;
        @(negedge hw_clk);
        check("dropped_clear", dropped, 0);
        check("no_extra_bytes", tx_valid, 0);
        check($sformatf("sat_after_%0d", d), sat, exp_sat);
        tx_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        dist_valid = 1'b0;
        dist_cm    = '0;
        tx_ready   = 1'b0;
        repeat (2) @(negedge hw_clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_sat", sat, 0);
        check("rst_dropped", dropped, 0);
        rst = 1'b0;

        run_record(234, 0, -1, -1);
        run_record(7, 0, -1, -1);
        run_record(0, 0, -1, -1);
        run_record(1023, 0, -1, -1);
        run_record(50, 0, -1, -1);
        run_record(400, 2, 2, -1);
        run_record(321, 0, -1, 3);
        run_record(654, 0, -1, 7);

        // Abort a record at idx4 with an asynchronous reset.
        model(1000);
        @(negedge hw_clk);
        dist_valid = 1'b1;
        dist_cm    = DIST_W'(1000);
        tx_ready   = 1'b1;
        @(negedge hw_clk);
        dist_valid = 1'b0;
        n = 0;
        while (!tx_valid && n < 50) begin
            @(negedge hw_clk);
            n++;
        end
        repeat (4) @(negedge hw_clk);
        check("pre_rst_idx4", tx_data, exp_q[4]);
        check("pre_rst_sat", sat, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tx_data", tx_data, 8'h00);
        check("mid_rst_sat", sat, 0);
        @(negedge hw_clk);
        rst      = 1'b0;
        tx_ready = 1'b0;
        exp_sat  = 1'b0;
        run_record(123, 0, -1, -1);

`ifdef DIST_TX_OOR_EN
        run_record(450, 0, -1, -1);
        run_record(400, 0, -1, -1);
`endif

        for (int k = 0; k < 8; k++)
            run_record(int'($urandom_range(0, 1023)), 1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
